// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared types, constants and pricing helper for the vending controller
//
// Purpose: state enumeration, keypad digit width, BCD limit and the slot
// pricing function used by param_vending_machine.
// Ports: none (package).

package vm_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_TENS,
    ST_GET_ONES,
    ST_CHECK,
    ST_WAIT_TRAN,
    ST_VENDING,
    ST_DOOR_OPEN_WAIT,
    ST_HOLD
  } vm_state_e;

  // Price grows by one every two columns and by one per row, capped at the
  // largest value the COST bus can carry.
  function automatic int slot_cost(input int row, input int col, input int cost_w);
    int raw;
    int cap;
    raw = (col >> 1) + 1 + row;
    cap = (1 << cost_w) - 1;
    return (raw > cap) ? cap : raw;
  endfunction

endpackage

// File: rtl/vm_timeout_counter.sv
// rtl/vm_timeout_counter.sv - per-state wait timer for the vending controller
//
// Purpose: counts cycles spent in the current wait state, saturating at TIMEOUT.
// Ports:
//   clk_i      in  system clock, rising edge
//   rst_i      in  asynchronous active-high reset
//   clear_i    in  restart the count (asserted on every state change)
//   enable_i   in  current state is a timed wait state
//   expired_o  out the count reaches TIMEOUT on the coming edge

module vm_timeout_counter #(
  parameter int TIMEOUT = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != CNT_W'(TIMEOUT))) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Look-ahead compare so the state machine leaves on exactly the edge where
  // the count would become TIMEOUT (entry at edge n, exit at edge n+TIMEOUT).
  assign expired_o = enable_i && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/param_vending_machine.sv
// rtl/param_vending_machine.sv - card-operated vending controller top level
//
// Purpose: two-digit slot selection, stock tracking, payment wait and
// dispenser door handshake with registered status outputs.
// Ports:
//   clk_i          in  system clock, rising edge
//   rst_i          in  asynchronous active-high reset
//   reload_i       in  refill every slot with RELOAD_QTY (IDLE only)
//   card_in_i      in  card present (level)
//   cancel_i       in  abort current selection (pulse)
//   item_code_i    in  BCD digit, sampled with key_press_i
//   key_press_i    in  one-cycle digit strobe
//   valid_tran_i   in  payment approved (pulse)
//   door_open_i    in  dispenser door state (level)
//   vend_o         out item released
//   invalid_sel_o  out selection code out of range
//   sold_out_o     out valid code but slot empty
//   cost_o         out price of the selected slot
//   failed_tran_o  out payment not approved in time

module param_vending_machine
  import vm_pkg::*;
#(
  parameter int NUM_ROWS   = 2,
  parameter int NUM_COLS   = 10,
  parameter int STOCK_W    = 4,
  parameter int RELOAD_QTY = 10,
  parameter int TIMEOUT    = 5,
  parameter int COST_W     = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               reload_i,
  input  logic               card_in_i,
  input  logic               cancel_i,
  input  logic [DIGIT_W-1:0] item_code_i,
  input  logic               key_press_i,
  input  logic               valid_tran_i,
  input  logic               door_open_i,
  output logic               vend_o,
  output logic               invalid_sel_o,
  output logic               sold_out_o,
  output logic [COST_W-1:0]  cost_o,
  output logic               failed_tran_o
);

  localparam int NUM_SLOTS = NUM_ROWS * NUM_COLS;
  localparam int IDX_W     = (NUM_SLOTS < 2) ? 1 : $clog2(NUM_SLOTS);

  vm_state_e          state_q, state_d;
  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;
  logic               vend_q, vend_d;
  logic               invalid_q, invalid_d;
  logic               sold_q, sold_d;
  logic               failed_q, failed_d;
  logic [COST_W-1:0]  cost_q, cost_d;

  logic [STOCK_W-1:0] stock_q [NUM_SLOTS];

  logic               reload_all;
  logic               dec_en;
  logic               go_idle;
  logic               abort;
  logic               code_ok;
  logic [IDX_W-1:0]   chk_idx;
  logic               timed_state;
  logic               timer_expired;

  assign abort = ~card_in_i | cancel_i;

  // A code is only usable when both digits are BCD and land inside the grid.
  assign code_ok = (tens_q <= BCD_MAX) && (ones_q <= BCD_MAX) &&
                   (int'(tens_q) < NUM_ROWS) && (int'(ones_q) < NUM_COLS);

  // Forced to slot 0 for bad codes so the stock lookup never goes out of range.
  assign chk_idx = code_ok ? IDX_W'(int'(tens_q) * NUM_COLS + int'(ones_q)) : '0;

  assign timed_state = (state_q == ST_GET_TENS) || (state_q == ST_GET_ONES) ||
                       (state_q == ST_WAIT_TRAN) || (state_q == ST_VENDING);

  vm_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_d != state_q),
    .enable_i  (timed_state),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    sel_idx_d  = sel_idx_q;
    vend_d     = vend_q;
    invalid_d  = invalid_q;
    sold_d     = sold_q;
    failed_d   = failed_q;
    cost_d     = cost_q;
    reload_all = 1'b0;
    dec_en     = 1'b0;
    go_idle    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        go_idle = 1'b1;
        // Reload wins over a card arriving in the same cycle; the card is a
        // level so it is picked up on the following cycle.
        if (reload_i) begin
          reload_all = 1'b1;
        end else if (card_in_i) begin
          go_idle = 1'b0;
          state_d = ST_GET_TENS;
        end
      end

      ST_GET_TENS: begin
        if (abort) begin
          go_idle = 1'b1;
        end else if (key_press_i) begin
          tens_d  = item_code_i;
          state_d = ST_GET_ONES;
        end else if (timer_expired) begin
          go_idle = 1'b1;
        end
      end

      ST_GET_ONES: begin
        if (abort) begin
          go_idle = 1'b1;
        end else if (key_press_i) begin
          ones_d  = item_code_i;
          state_d = ST_CHECK;
        end else if (timer_expired) begin
          go_idle = 1'b1;
        end
      end

      ST_CHECK: begin
        if (abort) begin
          go_idle = 1'b1;
        end else if (!code_ok) begin
          invalid_d = 1'b1;
          state_d   = ST_HOLD;
        end else if (stock_q[chk_idx] == '0) begin
          sold_d  = 1'b1;
          state_d = ST_HOLD;
        end else begin
          sel_idx_d = chk_idx;
          cost_d    = COST_W'(slot_cost(int'(tens_q), int'(ones_q), COST_W));
          state_d   = ST_WAIT_TRAN;
        end
      end

      ST_WAIT_TRAN: begin
        if (abort) begin
          go_idle = 1'b1;
        end else if (valid_tran_i) begin
          dec_en  = 1'b1;
          vend_d  = 1'b1;
          state_d = ST_VENDING;
        end else if (timer_expired) begin
          failed_d = 1'b1;
          state_d  = ST_HOLD;
        end
      end

      ST_VENDING: begin
        if (door_open_i) begin
          cost_d  = '0;
          state_d = ST_DOOR_OPEN_WAIT;
        end else if (timer_expired) begin
          go_idle = 1'b1;
        end
      end

      ST_DOOR_OPEN_WAIT: begin
        if (!door_open_i) begin
          go_idle = 1'b1;
        end
      end

      ST_HOLD: begin
        if (!card_in_i) begin
          go_idle = 1'b1;
        end
      end

      default: begin
        go_idle = 1'b1;
      end
    endcase

    if (go_idle) begin
      state_d   = ST_IDLE;
      vend_d    = 1'b0;
      invalid_d = 1'b0;
      sold_d    = 1'b0;
      failed_d  = 1'b0;
      cost_d    = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      tens_q    <= '0;
      ones_q    <= '0;
      sel_idx_q <= '0;
      vend_q    <= 1'b0;
      invalid_q <= 1'b0;
      sold_q    <= 1'b0;
      failed_q  <= 1'b0;
      cost_q    <= '0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      sel_idx_q <= sel_idx_d;
      vend_q    <= vend_d;
      invalid_q <= invalid_d;
      sold_q    <= sold_d;
      failed_q  <= failed_d;
      cost_q    <= cost_d;
    end
  end

  // The zero guard keeps the counter from wrapping even though CHECK already
  // refuses empty slots.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        stock_q[i] <= '0;
      end
    end else if (reload_all) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        stock_q[i] <= STOCK_W'(RELOAD_QTY);
      end
    end else if (dec_en && (stock_q[sel_idx_q] != '0)) begin
      stock_q[sel_idx_q] <= stock_q[sel_idx_q] - STOCK_W'(1);
    end
  end

  assign vend_o        = vend_q;
  assign invalid_sel_o = invalid_q;
  assign sold_out_o    = sold_q;
  assign cost_o        = cost_q;
  assign failed_tran_o = failed_q;

endmodule

// File: tb/tb_param_vending_machine.sv
// tb/tb_param_vending_machine.sv - scenario bench for param_vending_machine

module tb_param_vending_machine;
  import vm_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       reload = 1'b0;
  logic       card_in = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] item_code = 4'd0;
  logic       key_press = 1'b0;
  logic       valid_tran = 1'b0;
  logic       door_open = 1'b0;
  logic       vend;
  logic       invalid_sel;
  logic       sold_out;
  logic [2:0] cost;
  logic       failed_tran;

  int total = 0;
  int bad = 0;
  int model_stock [20];
  int exp_cost_q [$];

  param_vending_machine #(
    .NUM_ROWS(2), .NUM_COLS(10), .STOCK_W(4), .RELOAD_QTY(10), .TIMEOUT(5), .COST_W(3)
  ) dut (
    .clk_i(clk), .rst_i(rst), .reload_i(reload), .card_in_i(card_in), .cancel_i(cancel),
    .item_code_i(item_code), .key_press_i(key_press), .valid_tran_i(valid_tran),
    .door_open_i(door_open), .vend_o(vend), .invalid_sel_o(invalid_sel),
    .sold_out_o(sold_out), .cost_o(cost), .failed_tran_o(failed_tran)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; reload = 1'b0; card_in = 1'b0; cancel = 1'b0;
    key_press = 1'b0; valid_tran = 1'b0; door_open = 1'b0; item_code = 4'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) model_stock[i] = 0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    for (int i = 0; i < 20; i++) model_stock[i] = 10;
  endtask

  // Leaves the DUT one edge after CHECK, so the outcome is visible on outputs.
  task automatic select_code(input logic [3:0] t, input logic [3:0] o);
    card_in = 1'b1; tick();
    item_code = t; key_press = 1'b1; tick(); key_press = 1'b0;
    item_code = o; key_press = 1'b1; tick(); key_press = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({vend, invalid_sel, sold_out, failed_tran, cost} !== 7'd0) begin
      bad++; $display("FAIL reset_outputs: got %b expected 0", {vend, invalid_sel, sold_out, failed_tran, cost});
    end
    total++;
    if (dut.state_q !== ST_IDLE) begin
      bad++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE);
    end
    total++;
    if (dut.stock_q[11] !== 4'(model_stock[11])) begin
      bad++; $display("FAIL reset_stock: got %0d expected %0d", dut.stock_q[11], model_stock[11]);
    end
  endtask

  task automatic test_vend();
    int exp;
    do_reload();
    total++;
    if (dut.stock_q[11] !== 4'(model_stock[11])) begin
      bad++; $display("FAIL reload_stock: got %0d expected %0d", dut.stock_q[11], model_stock[11]);
    end
    select_code(4'd1, 4'd1);
    total++;
    if (cost !== 3'd2 || vend !== 1'b0) begin
      bad++; $display("FAIL vend_cost: got cost=%0d vend=%0b expected cost=2 vend=0", cost, vend);
    end
    exp_cost_q.push_back(2);
    model_stock[11]--;
    valid_tran = 1'b1; tick(); valid_tran = 1'b0;
    total++;
    if (vend !== 1'b1) begin
      bad++; $display("FAIL vend_rise: got %0b expected 1", vend);
    end
    if (vend === 1'b1) begin
      total++;
      if (exp_cost_q.size() == 0) begin
        bad++; $display("FAIL vend_sb: got unexpected vend expected none");
      end else begin
        exp = exp_cost_q.pop_front();
        if (cost !== 3'(exp)) begin
          bad++; $display("FAIL vend_sb_cost: got %0d expected %0d", cost, exp);
        end
      end
    end
    door_open = 1'b1; tick(); tick();
    total++;
    if (vend !== 1'b1) begin
      bad++; $display("FAIL vend_door_open: got %0b expected 1", vend);
    end
    door_open = 1'b0; card_in = 1'b0; tick();
    total++;
    if (vend !== 1'b0 || cost !== 3'd0) begin
      bad++; $display("FAIL vend_door_close: got vend=%0b cost=%0d expected 0 0", vend, cost);
    end
    total++;
    if (dut.stock_q[11] !== 4'(model_stock[11])) begin
      bad++; $display("FAIL vend_stock: got %0d expected %0d", dut.stock_q[11], model_stock[11]);
    end
    tick();
  endtask

  task automatic test_invalid();
    select_code(4'd9, 4'd9);
    total++;
    if (invalid_sel !== 1'b1 || cost !== 3'd0) begin
      bad++; $display("FAIL invalid_99: got inv=%0b cost=%0d expected 1 0", invalid_sel, cost);
    end
    tick(); tick(); tick();
    total++;
    if (invalid_sel !== 1'b1) begin
      bad++; $display("FAIL invalid_hold: got %0b expected 1", invalid_sel);
    end
    card_in = 1'b0; tick();
    total++;
    if (invalid_sel !== 1'b0) begin
      bad++; $display("FAIL invalid_clear: got %0b expected 0", invalid_sel);
    end
    select_code(4'hA, 4'd0);
    total++;
    if (invalid_sel !== 1'b1 || sold_out !== 1'b0) begin
      bad++; $display("FAIL invalid_hex_tens: got inv=%0b so=%0b expected 1 0", invalid_sel, sold_out);
    end
    card_in = 1'b0; tick();
  endtask

  task automatic test_key_timeout();
    card_in = 1'b1; tick();
    repeat (4) tick();
    total++;
    if (dut.state_q !== ST_GET_TENS) begin
      bad++; $display("FAIL key_timeout_early: got %0d expected %0d", dut.state_q, ST_GET_TENS);
    end
    tick();
    total++;
    if (dut.state_q !== ST_IDLE || {invalid_sel, sold_out, failed_tran, vend} !== 4'd0) begin
      bad++; $display("FAIL key_timeout_exit: got state=%0d flags=%b expected %0d 0000",
                      dut.state_q, {invalid_sel, sold_out, failed_tran, vend}, ST_IDLE);
    end
    card_in = 1'b0; tick();
  endtask

  task automatic test_failed_tran();
    select_code(4'd0, 4'd1);
    total++;
    if (cost !== 3'd1 || failed_tran !== 1'b0) begin
      bad++; $display("FAIL ft_entry: got cost=%0d ft=%0b expected 1 0", cost, failed_tran);
    end
    repeat (4) tick();
    total++;
    if (failed_tran !== 1'b0) begin
      bad++; $display("FAIL ft_early: got %0b expected 0", failed_tran);
    end
    tick();
    total++;
    if (failed_tran !== 1'b1 || cost !== 3'd1) begin
      bad++; $display("FAIL ft_fire: got ft=%0b cost=%0d expected 1 1", failed_tran, cost);
    end
    card_in = 1'b0; tick();
    total++;
    if (failed_tran !== 1'b0 || cost !== 3'd0) begin
      bad++; $display("FAIL ft_clear: got ft=%0b cost=%0d expected 0 0", failed_tran, cost);
    end
  endtask

  task automatic test_vend_timeout();
    int exp;
    select_code(4'd0, 4'd2);
    exp_cost_q.push_back(2);
    model_stock[2]--;
    valid_tran = 1'b1; tick(); valid_tran = 1'b0;
    total++;
    if (vend !== 1'b1) begin
      bad++; $display("FAIL vt_rise: got %0b expected 1", vend);
    end
    if (vend === 1'b1) begin
      total++;
      if (exp_cost_q.size() == 0) begin
        bad++; $display("FAIL vt_sb: got unexpected vend expected none");
      end else begin
        exp = exp_cost_q.pop_front();
        if (cost !== 3'(exp)) begin
          bad++; $display("FAIL vt_sb_cost: got %0d expected %0d", cost, exp);
        end
      end
    end
    repeat (4) tick();
    total++;
    if (vend !== 1'b1) begin
      bad++; $display("FAIL vt_early: got %0b expected 1", vend);
    end
    tick();
    total++;
    if (vend !== 1'b0) begin
      bad++; $display("FAIL vt_drop: got %0b expected 0", vend);
    end
    total++;
    if (dut.stock_q[2] !== 4'(model_stock[2])) begin
      bad++; $display("FAIL vt_stock: got %0d expected %0d", dut.stock_q[2], model_stock[2]);
    end
    card_in = 1'b0; tick();
  endtask

  task automatic test_cancel();
    select_code(4'd0, 4'd3);
    valid_tran = 1'b1; cancel = 1'b1; tick();
    valid_tran = 1'b0; cancel = 1'b0;
    total++;
    if (vend !== 1'b0 || cost !== 3'd0) begin
      bad++; $display("FAIL cancel_out: got vend=%0b cost=%0d expected 0 0", vend, cost);
    end
    total++;
    if (dut.stock_q[3] !== 4'(model_stock[3])) begin
      bad++; $display("FAIL cancel_stock: got %0d expected %0d", dut.stock_q[3], model_stock[3]);
    end
    card_in = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    int exp;
    select_code(4'd1, 4'd9);
    total++;
    if (cost !== 3'd6) begin
      bad++; $display("FAIL b2b_cost19: got %0d expected 6", cost);
    end
    exp_cost_q.push_back(6);
    model_stock[19]--;
    valid_tran = 1'b1; tick(); valid_tran = 1'b0;
    if (vend === 1'b1) begin
      total++;
      if (exp_cost_q.size() == 0) begin
        bad++; $display("FAIL b2b_sb: got unexpected vend expected none");
      end else begin
        exp = exp_cost_q.pop_front();
        if (cost !== 3'(exp)) begin
          bad++; $display("FAIL b2b_sb_cost: got %0d expected %0d", cost, exp);
        end
      end
    end
    door_open = 1'b1; tick(); door_open = 1'b0; card_in = 1'b0; tick();
    select_code(4'd1, 4'd0);
    total++;
    if (cost !== 3'd2 || sold_out !== 1'b0) begin
      bad++; $display("FAIL b2b_cost10: got cost=%0d so=%0b expected 2 0", cost, sold_out);
    end
    total++;
    if (dut.stock_q[19] !== 4'(model_stock[19])) begin
      bad++; $display("FAIL b2b_stock: got %0d expected %0d", dut.stock_q[19], model_stock[19]);
    end
    card_in = 1'b0; tick();
  endtask

  task automatic test_async_reset();
    select_code(4'd0, 4'd4);
    total++;
    if (cost !== 3'd3) begin
      bad++; $display("FAIL ar_cost: got %0d expected 3", cost);
    end
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) model_stock[i] = 0;
    total++;
    if ({vend, invalid_sel, sold_out, failed_tran, cost} !== 7'd0) begin
      bad++; $display("FAIL ar_outputs: got %b expected 0", {vend, invalid_sel, sold_out, failed_tran, cost});
    end
    total++;
    if (dut.stock_q[4] !== 4'(model_stock[4])) begin
      bad++; $display("FAIL ar_stock: got %0d expected %0d", dut.stock_q[4], model_stock[4]);
    end
    card_in = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sold_out_reload_ignored();
    card_in = 1'b1; tick();
    item_code = 4'd0; key_press = 1'b1; tick(); key_press = 1'b0;
    reload = 1'b1; tick(); reload = 1'b0;
    total++;
    if (dut.stock_q[0] !== 4'(model_stock[0])) begin
      bad++; $display("FAIL reload_ignored: got %0d expected %0d", dut.stock_q[0], model_stock[0]);
    end
    item_code = 4'd0; key_press = 1'b1; tick(); key_press = 1'b0;
    tick();
    total++;
    if (sold_out !== 1'b1 || cost !== 3'd0 || vend !== 1'b0 || invalid_sel !== 1'b0) begin
      bad++; $display("FAIL sold_out: got so=%0b cost=%0d vend=%0b inv=%0b expected 1 0 0 0",
                      sold_out, cost, vend, invalid_sel);
    end
    card_in = 1'b0; tick();
    total++;
    if (sold_out !== 1'b0) begin
      bad++; $display("FAIL sold_out_clear: got %0b expected 0", sold_out);
    end
  endtask

  initial begin
    test_reset();
    test_vend();
    test_invalid();
    test_key_timeout();
    test_failed_tran();
    test_vend_timeout();
    test_cancel();
    test_back_to_back();
    test_async_reset();
    test_sold_out_reload_ignored();
    total++;
    if (exp_cost_q.size() != 0) begin
      bad++; $display("FAIL sb_drain: got %0d pending expected 0", exp_cost_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
